// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding, default sizes, index width helper.
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_ADDR_WIDTH   = 5;
    localparam int unsigned DEF_REGFILE_SIZE = 32;
    localparam int unsigned DEF_NUM_RD       = 2;
    localparam int unsigned DEF_NUM_WR       = 1;
    localparam int unsigned DEF_ZERO_REG     = 1;

    // Width of a register index / clear counter; never below one bit.
    function automatic int unsigned idx_width(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    localparam int unsigned DEF_CNT_WIDTH = idx_width(DEF_REGFILE_SIZE);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = DEF_NUM_RD,
    parameter int unsigned NUM_WR     = DEF_NUM_WR
);
    logic                         init_done;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_pending;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         pend_set;
    logic [ADDR_WIDTH-1:0]        pend_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        input  init_done, rd_data, rd_pending
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        output init_done, rd_data, rd_pending
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: clears from writes, set from issue (set wins), registered lookups.
// With REGFILE_MP_BYPASS_EN the lookup sees the post-edge scoreboard value.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned REGFILE_SIZE = DEF_REGFILE_SIZE,
    parameter int unsigned NUM_RD       = DEF_NUM_RD,
    parameter int unsigned NUM_WR       = DEF_NUM_WR,
    parameter int unsigned IDX_W        = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         pend_set,
    input  logic [ADDR_WIDTH-1:0]        pend_addr,
    input  logic [NUM_WR-1:0]            clr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] clr_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_pending
);

    logic [REGFILE_SIZE-1:0] pend_q;
    logic [REGFILE_SIZE-1:0] pend_d;
    logic [REGFILE_SIZE-1:0] lookup_c;

    // Clears first, then the issue set so a new producer overrides a retiring one.
    always_comb begin
        pend_d = pend_q;
        if (en) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (clr_en[p]) begin
                    pend_d[IDX_W'(clr_addr[p*ADDR_WIDTH +: ADDR_WIDTH])] = 1'b0;
                end
            end
            if (pend_set) begin
                pend_d[IDX_W'(pend_addr)] = 1'b1;
            end
        end
    end

`ifdef REGFILE_MP_BYPASS_EN
    assign lookup_c = pend_d;
`else
    assign lookup_c = pend_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            rd_pending <= '0;
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_pending[i] <= en
                    && (32'(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) < REGFILE_SIZE)
                    && lookup_c[IDX_W'(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardware clear sweep and pending scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned REGFILE_SIZE = DEF_REGFILE_SIZE,
    parameter int unsigned NUM_RD       = DEF_NUM_RD,
    parameter int unsigned NUM_WR       = DEF_NUM_WR,
    parameter int unsigned ZERO_REG     = DEF_ZERO_REG
) (
    input  logic       clk,
    input  logic       rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(REGFILE_SIZE);

    state_t                       state_q;
    state_t                       state_d;
    logic [IDX_W-1:0]             cnt_q;
    logic [IDX_W-1:0]             cnt_d;
    logic                         clr_we_c;
    logic                         run;
    logic [NUM_WR-1:0]            wr_ok_c;
    logic                         pend_ok_c;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_val_c;
    logic [DATA_WIDTH-1:0]        mem [REGFILE_SIZE];

    // An address names a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < REGFILE_SIZE) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign run = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= '0;
            bus.init_done <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus.init_done <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_c = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                if (cnt_q == IDX_W'(REGFILE_SIZE - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
            end
        endcase
    end

    always_comb begin
        wr_ok_c = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_ok_c[p] = run && bus.wr_en[p] && addr_ok(bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        pend_ok_c = run && bus.pend_set && addr_ok(bus.pend_addr);
    end

    // Later ports are assigned last, so the highest-indexed port wins a conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we_c) begin
                mem[cnt_q] <= '0;
            end
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok_c[p]) begin
                    mem[IDX_W'(bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH])] <= bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_val_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_ok(bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rd_val_c[i*DATA_WIDTH +: DATA_WIDTH] = mem[IDX_W'(bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])];
            end
`ifdef REGFILE_MP_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok_c[p] && (bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rd_val_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= run ? rd_val_c : '0;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .REGFILE_SIZE (REGFILE_SIZE),
        .NUM_RD       (NUM_RD),
        .NUM_WR       (NUM_WR),
        .IDX_W        (IDX_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.init_done),
        .pend_set   (pend_ok_c),
        .pend_addr  (bus.pend_addr),
        .clr_en     (wr_ok_c),
        .clr_addr   (bus.wr_addr),
        .rd_addr    (bus.rd_addr),
        .rd_pending (bus.rd_pending)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports, 6-bit addresses over 32 registers).
module tb_regfile_mp;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 6;
    localparam int unsigned SIZE = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   chk_on;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    regfile_mp #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .REGFILE_SIZE (SIZE),
        .NUM_RD       (NRD),
        .NUM_WR       (NWR),
        .ZERO_REG     (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural register and pending arrays plus a sweep countdown.
    logic [DW-1:0] m_mem  [SIZE];
    logic [DW-1:0] m_nmem [SIZE];
    bit            m_pend [SIZE];
    bit            m_npend[SIZE];
    int            sweep_left = SIZE;
    bit            exp_init;
    logic [DW-1:0] exp_data[NRD];
    bit            exp_pend[NRD];

    function automatic bit usable(input int a);
        return (a >= 1) && (a < int'(SIZE));
    endfunction

    always @(posedge clk) begin
        int a;
        if (rst) begin
            sweep_left = SIZE;
            exp_init   = 1'b0;
            for (int r = 0; r < NRD; r++) begin exp_data[r] = '0; exp_pend[r] = 1'b0; end
            for (int k = 0; k < SIZE; k++) m_pend[k] = 1'b0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            for (int r = 0; r < NRD; r++) begin exp_data[r] = '0; exp_pend[r] = 1'b0; end
            if (sweep_left == 0) begin
                exp_init = 1'b1;
                for (int k = 0; k < SIZE; k++) m_mem[k] = '0;
            end
        end else begin
            m_nmem  = m_mem;
            m_npend = m_pend;
            for (int w = 0; w < NWR; w++) begin
                a = int'(bus.wr_addr[w*AW +: AW]);
                if (bus.wr_en[w] && usable(a)) begin
                    m_nmem[a]  = bus.wr_data[w*DW +: DW];
                    m_npend[a] = 1'b0;
                end
            end
            a = int'(bus.pend_addr);
            if (bus.pend_set && usable(a)) m_npend[a] = 1'b1;
            for (int r = 0; r < NRD; r++) begin
                a = int'(bus.rd_addr[r*AW +: AW]);
                exp_data[r] = '0;
                exp_pend[r] = 1'b0;
                if (usable(a)) begin
`ifdef REGFILE_MP_BYPASS_EN
                    exp_data[r] = m_nmem[a];
                    exp_pend[r] = m_npend[a];
`else
                    exp_data[r] = m_mem[a];
                    exp_pend[r] = m_pend[a];
`endif
                end
            end
            m_mem  = m_nmem;
            m_pend = m_npend;
        end
    end

    // Continuous compare of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("init_done", 32'(bus.init_done), 32'(exp_init));
            for (int r = 0; r < NRD; r++) begin
                check($sformatf("rd_data[%0d]", r), bus.rd_data[r*DW +: DW], exp_data[r]);
                check($sformatf("rd_pending[%0d]", r), 32'(bus.rd_pending[r]), 32'(exp_pend[r]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rd_addr   = '0;
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.pend_set  = 1'b0;
        bus.pend_addr = '0;
    endtask

    task automatic wr(input int port, input int addr, input logic [DW-1:0] d);
        bus.wr_en[port]             = 1'b1;
        bus.wr_addr[port*AW +: AW]  = AW'(addr);
        bus.wr_data[port*DW +: DW]  = d;
    endtask

    task automatic rd(input int port, input int addr);
        bus.rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic pset(input int addr);
        bus.pend_set  = 1'b1;
        bus.pend_addr = AW'(addr);
    endtask

    function automatic logic [DW-1:0] rdd(input int port);
        return bus.rd_data[port*DW +: DW];
    endfunction

    // Counts edges from rst release until init_done is seen; bounded.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_on   = 1'b0;
        rst      = 1'b1;
        idle();
        step();
        chk_on = 1'b1;
        step();
        check("reset_init_done", 32'(bus.init_done), 32'd0);
        check("reset_rd_data", rdd(0), 32'd0);

        // First sweep, reading a register while clearing.
        rst = 1'b0;
        rd(0, 5);
        rd(1, 31);
        wait_init("init_latency");
        idle();
        step();
        check("idle_read_r0", rdd(0), 32'd0);

        wr(0, 5, 32'h0960_1050);
        step();
        idle(); rd(0, 5);
        step();
        check("r5_data", rdd(0), 32'h0960_1050);
        check("r5_pending", 32'(bus.rd_pending[0]), 32'd0);

        idle(); wr(0, 0, 32'hFFFF_FFFF);
        step();
        idle(); rd(1, 0);
        step();
        check("r0_zero", rdd(1), 32'd0);

        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22);
        step();
        idle(); rd(0, 7);
        step();
        check("r7_conflict", rdd(0), 32'h22);

        idle(); wr(0, 3, 32'hABCD); rd(0, 3);
        step();
`ifdef REGFILE_MP_BYPASS_EN
        check("r3_same_edge", rdd(0), 32'hABCD);
`else
        check("r3_same_edge", rdd(0), 32'h0);
`endif
        idle(); rd(0, 3);
        step();
        check("r3_next", rdd(0), 32'hABCD);

        idle(); pset(9);
        step();
        idle(); rd(0, 9); rd(1, 9);
        step();
        check("r9_pend_set", 32'(bus.rd_pending[1]), 32'd1);
        idle(); wr(0, 9, 32'h99); pset(9);
        step();
        idle(); rd(0, 9);
        step();
        check("r9_set_wins", 32'(bus.rd_pending[0]), 32'd1);
        check("r9_data", rdd(0), 32'h99);
        idle(); wr(1, 9, 32'h55);
        step();
        idle(); rd(0, 9);
        step();
        check("r9_cleared", 32'(bus.rd_pending[0]), 32'd0);

        // Out-of-range write must not alias onto r8; out-of-range read returns 0.
        idle(); wr(1, 40, 32'hDEAD_BEEF); pset(41);
        step();
        idle(); rd(0, 8); rd(1, 40);
        step();
        check("oor_no_alias", rdd(0), 32'd0);
        check("oor_read", rdd(1), 32'd0);
        check("oor_pend", 32'(bus.rd_pending[0]), 32'd0);

        idle(); wr(0, 12, 32'h1234_5678); wr(1, 13, 32'h8765_4321); rd(0, 12); rd(1, 13);
        step();
        idle(); wr(1, 12, 32'hCAFE); rd(0, 12); rd(1, 13); pset(13);
        step();
        idle(); rd(0, 12); rd(1, 13);
        step();
        check("r12_data", rdd(0), 32'hCAFE);
        check("r13_pend", 32'(bus.rd_pending[1]), 32'd1);

        // Mid-sweep reset: write r4, restart, reset again at cnt=10.
        idle(); wr(0, 4, 32'h44);
        step();
        idle(); rd(0, 4);
        step();
        check("r4_before", rdd(0), 32'h44);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr(0, 4, 32'h77); pset(13);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(); wr(0, 2, 32'h2222); pset(14); rd(0, 4); rd(1, 2);
        wait_init("init_after_midclear");
        idle(); rd(0, 4); rd(1, 2);
        step();
        check("r4_cleared", rdd(0), 32'd0);
        check("r2_write_ignored", rdd(1), 32'd0);
        idle(); rd(0, 13); rd(1, 14);
        step();
        check("r13_pend_reset", 32'(bus.rd_pending[0]), 32'd0);
        check("r14_pend_ignored", 32'(bus.rd_pending[1]), 32'd0);

        idle();
        step();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
